// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute stage and EX/WB pipeline register of the 8-bit core.
//
// Takes the registered ID/EX outputs and does the following:
// - Performs MOVI/ADD/SUB.
// - Forwards the previous result into operand A.
// - Resolves JMP.
// - After a taken jump, turns the next SQUASH_DEPTH instructions into bubbles.
//
// All outputs are registered, so latency is one cycle.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   num1                rs register value from ID/EX
//   ImmData_out         immediate operand
//   inst_code_idex_out  [7:6] opcode, [5:3] rd, [2:0] rs
//   j_adr_out           jump address field (low 6 bits of target)
//   PCline_idex_out     PC of the instruction (upper 2 bits form target page)
//   PCsrc_idex_out      0 = jump candidate, 1 = sequential
//   Sel1_idex_out       1 = operand A from register/forward path, 0 = zero
//   RegWrite_idex_out   write enable from decode
//   WriteData_exwb_out  writeback data
//   WriteReg_exwb_out   writeback destination register
//   RegWrite_exwb_out   writeback enable
//   jump_taken, flush   one-cycle pulses on a taken jump
//   jump_target         {PCline[7:6], j_adr}; holds until the next taken jump
//   carry_flag          carry (ADD) or borrow (SUB) of the last ADD/SUB
//   zero_flag           result == 0 of the last ADD/SUB
module ex_wb_stage #(
  parameter int unsigned SQUASH_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] num1,
  input  logic [7:0] ImmData_out,
  input  logic [7:0] inst_code_idex_out,
  input  logic [5:0] j_adr_out,
  input  logic [7:0] PCline_idex_out,
  input  logic       PCsrc_idex_out,
  input  logic       Sel1_idex_out,
  input  logic       RegWrite_idex_out,
  output logic [7:0] WriteData_exwb_out,
  output logic [2:0] WriteReg_exwb_out,
  output logic       RegWrite_exwb_out,
  output logic       jump_taken,
  output logic [7:0] jump_target,
  output logic       flush,
  output logic       carry_flag,
  output logic       zero_flag
);

  typedef enum logic [1:0] {
    OpMovi = 2'b00,
    OpAdd  = 2'b01,
    OpSub  = 2'b10,
    OpJmp  = 2'b11
  } opcode_e;

  localparam logic [1:0] SquashLoad = 2'(SQUASH_DEPTH);

  // Pipeline state
  logic [7:0] write_data_q, write_data_d;
  logic [2:0] write_reg_q, write_reg_d;
  logic       reg_write_q, reg_write_d;
  logic       jump_taken_q, jump_taken_d;
  logic [7:0] jump_target_q, jump_target_d;
  logic       flush_q, flush_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [1:0] squash_cnt_q, squash_cnt_d;

  // Decode fields
  opcode_e    opcode;
  logic [2:0] rd;
  logic [2:0] rs;

  assign opcode = opcode_e'(inst_code_idex_out[7:6]);
  assign rd     = inst_code_idex_out[5:3];
  assign rs     = inst_code_idex_out[2:0];

  // Operand A with forwarding from the instruction now in EX/WB. A bubble
  // leaves reg_write_q low, so it never acts as a forwarding source.
  logic       fwd;
  logic [7:0] a_raw;
  logic [7:0] op_a;
  logic       squashed;

  assign fwd      = reg_write_q && (write_reg_q == rs);
  assign a_raw    = fwd ? write_data_q : num1;
  assign op_a     = Sel1_idex_out ? a_raw : 8'h00;
  assign squashed = (squash_cnt_q != 2'd0);

  // Zero-extend both operands to 9 bits: bit 8 is the carry for ADD and the
  // borrow (op_a < imm) for SUB.
  logic [8:0] sum;
  logic [8:0] diff;

  assign sum  = {1'b0, op_a} + {1'b0, ImmData_out};
  assign diff = {1'b0, op_a} - {1'b0, ImmData_out};

  always_comb begin
    write_data_d  = write_data_q;
    write_reg_d   = write_reg_q;
    reg_write_d   = 1'b0;
    jump_taken_d  = 1'b0;
    jump_target_d = jump_target_q;
    flush_d       = 1'b0;
    carry_d       = carry_q;
    zero_d        = zero_q;
    squash_cnt_d  = squash_cnt_q;

    if (squashed) begin
      // Wrong-path bubble. A jump here is ignored, so the window cannot be
      // extended.
      squash_cnt_d = squash_cnt_q - 2'd1;
    end else begin
      unique case (opcode)
        OpMovi: begin
          write_data_d = ImmData_out;
          write_reg_d  = rd;
          reg_write_d  = RegWrite_idex_out;
        end
        OpAdd: begin
          write_data_d = sum[7:0];
          write_reg_d  = rd;
          reg_write_d  = RegWrite_idex_out;
          carry_d      = sum[8];
          zero_d       = (sum[7:0] == 8'h00);
        end
        OpSub: begin
          write_data_d = diff[7:0];
          write_reg_d  = rd;
          reg_write_d  = RegWrite_idex_out;
          carry_d      = diff[8];
          zero_d       = (diff[7:0] == 8'h00);
        end
        OpJmp: begin
          if (!PCsrc_idex_out) begin
            jump_taken_d  = 1'b1;
            flush_d       = 1'b1;
            jump_target_d = {PCline_idex_out[7:6], j_adr_out};
            squash_cnt_d  = SquashLoad;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_data_q  <= 8'h00;
      write_reg_q   <= 3'd0;
      reg_write_q   <= 1'b0;
      jump_taken_q  <= 1'b0;
      jump_target_q <= 8'h00;
      flush_q       <= 1'b0;
      carry_q       <= 1'b0;
      zero_q        <= 1'b0;
      squash_cnt_q  <= 2'd0;
    end else begin
      write_data_q  <= write_data_d;
      write_reg_q   <= write_reg_d;
      reg_write_q   <= reg_write_d;
      jump_taken_q  <= jump_taken_d;
      jump_target_q <= jump_target_d;
      flush_q       <= flush_d;
      carry_q       <= carry_d;
      zero_q        <= zero_d;
      squash_cnt_q  <= squash_cnt_d;
    end
  end

  assign WriteData_exwb_out = write_data_q;
  assign WriteReg_exwb_out  = write_reg_q;
  assign RegWrite_exwb_out  = reg_write_q;
  assign jump_taken         = jump_taken_q;
  assign jump_target        = jump_target_q;
  assign flush              = flush_q;
  assign carry_flag         = carry_q;
  assign zero_flag          = zero_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Bench for ex_wb_stage.
// A driver issues one instruction per cycle at the negative edge. A reference
// model computes the expected registered outputs and pushes them into a queue.
// A monitor pops the queue one cycle later and compares against the DUT.
module tb_ex_wb_stage;

  localparam int unsigned Depth = 2;

  logic       clk;
  logic       reset;
  logic [7:0] num1;
  logic [7:0] imm;
  logic [7:0] inst;
  logic [5:0] j_adr;
  logic [7:0] pcline;
  logic       pcsrc;
  logic       sel1;
  logic       rw_in;
  logic [7:0] wd;
  logic [2:0] wr;
  logic       rw;
  logic       jt;
  logic [7:0] jtgt;
  logic       fl;
  logic       cf;
  logic       zf;

  ex_wb_stage #(.SQUASH_DEPTH(Depth)) dut (
    .clk                (clk),
    .reset              (reset),
    .num1               (num1),
    .ImmData_out        (imm),
    .inst_code_idex_out (inst),
    .j_adr_out          (j_adr),
    .PCline_idex_out    (pcline),
    .PCsrc_idex_out     (pcsrc),
    .Sel1_idex_out      (sel1),
    .RegWrite_idex_out  (rw_in),
    .WriteData_exwb_out (wd),
    .WriteReg_exwb_out  (wr),
    .RegWrite_exwb_out  (rw),
    .jump_taken         (jt),
    .jump_target        (jtgt),
    .flush              (fl),
    .carry_flag         (cf),
    .zero_flag          (zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] wd;
    logic [2:0] wr;
    logic       rw;
    logic       jt;
    logic [7:0] jtgt;
    logic       fl;
    logic       cf;
    logic       zf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: architectural view of the last write, flags, target,
  // and how many wrong-path slots remain.
  int m_wd, m_wr, m_rw, m_jt, m_tgt, m_fl, m_c, m_z, m_left;

  task automatic model_step(input bit rst, input int op, input int rd, input int rs,
                            input int n1, input int im, input int ja, input int pc,
                            input bit ps, input bit s1, input bit we);
    int a;
    int res;
    if (rst) begin
      m_wd = 0; m_wr = 0; m_rw = 0; m_jt = 0; m_tgt = 0; m_fl = 0;
      m_c = 0; m_z = 0; m_left = 0;
      return;
    end
    m_jt = 0;
    m_fl = 0;
    if (m_left > 0) begin
      m_rw   = 0;
      m_left = m_left - 1;
      return;
    end
    if (!s1) a = 0;
    else if (m_rw == 1 && m_wr == rs) a = m_wd;
    else a = n1;
    case (op)
      0: begin m_wd = im; m_wr = rd; m_rw = we; end
      1: begin
        res = a + im;
        m_c = (res > 255) ? 1 : 0;
        res = res % 256;
        m_z = (res == 0) ? 1 : 0;
        m_wd = res; m_wr = rd; m_rw = we;
      end
      2: begin
        m_c = (a < im) ? 1 : 0;
        res = (a - im + 256) % 256;
        m_z = (res == 0) ? 1 : 0;
        m_wd = res; m_wr = rd; m_rw = we;
      end
      default: begin
        m_rw = 0;
        if (!ps) begin
          m_jt = 1; m_fl = 1;
          m_tgt = (pc / 64) * 64 + ja;
          m_left = Depth;
        end
      end
    endcase
  endtask

  task automatic issue(input bit rst, input int op, input int rd, input int rs,
                       input int n1, input int im, input int ja, input int pc,
                       input bit ps, input bit s1, input bit we);
    obs_t e;
    @(negedge clk);
    reset  = rst;
    inst   = {2'(op), 3'(rd), 3'(rs)};
    num1   = 8'(n1);
    imm    = 8'(im);
    j_adr  = 6'(ja);
    pcline = 8'(pc);
    pcsrc  = ps;
    sel1   = s1;
    rw_in  = we;
    model_step(rst, op, rd, rs, n1, im, ja, pc, ps, s1, we);
    e.wd   = 8'(m_wd);
    e.wr   = 3'(m_wr);
    e.rw   = m_rw[0];
    e.jt   = m_jt[0];
    e.jtgt = 8'(m_tgt);
    e.fl   = m_fl[0];
    e.cf   = m_c[0];
    e.zf   = m_z[0];
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    issue(1'b1, int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(7)),
          int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(63)),
          int'($urandom_range(255)), 1'b0, 1'b1, 1'b1);
  endtask

  task automatic movi(input int rd, input int im, input bit we);
    issue(1'b0, 0, rd, 0, 0, im, 0, 0, 1'b1, 1'b1, we);
  endtask

  task automatic alu(input int op, input int rd, input int rs, input int n1, input int im);
    issue(1'b0, op, rd, rs, n1, im, 0, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic jmp(input bit ps, input int pc, input int ja);
    issue(1'b0, 3, 0, 0, 0, 0, ja, pc, ps, 1'b1, 1'b1);
  endtask

  // Monitor: every output cycle is compared with the next expected entry.
  always @(posedge clk) begin
    obs_t e;
    obs_t act;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = '{wd: wd, wr: wr, rw: rw, jt: jt, jtgt: jtgt, fl: fl, cf: cf, zf: zf};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got wd=%h wr=%0d rw=%b jt=%b tgt=%h fl=%b c=%b z=%b, want wd=%h wr=%0d rw=%b jt=%b tgt=%h fl=%b c=%b z=%b",
                 $time, act.wd, act.wr, act.rw, act.jt, act.jtgt, act.fl, act.cf, act.zf,
                 e.wd, e.wr, e.rw, e.jt, e.jtgt, e.fl, e.cf, e.zf);
      end
    end
  end

  initial begin
    reset = 1'b1; num1 = '0; imm = '0; inst = '0; j_adr = '0;
    pcline = '0; pcsrc = 1'b1; sel1 = 1'b0; rw_in = 1'b0;

    // Reset with arbitrary inputs, then MOVI.
    do_reset();
    do_reset();
    movi(3, 'h5A, 1'b1);

    // ADD wrap, SUB to zero, SUB with borrow (rs chosen so no forwarding).
    alu(1, 4, 0, 'hF0, 'h20);
    alu(2, 5, 1, 'h05, 'h05);
    alu(2, 6, 1, 'h03, 'h04);

    // Forwarding enabled, then disabled via RegWrite=0.
    movi(2, 'h07, 1'b1);
    alu(1, 1, 2, 'h00, 'h01);
    movi(2, 'h07, 1'b0);
    alu(1, 1, 2, 'h00, 'h01);

    // Taken jump followed by a 2-slot squash window.
    jmp(1'b0, 'hC4, 'h15);
    alu(1, 1, 0, 'h10, 'h10);
    alu(1, 2, 0, 'h00, 'h00);
    alu(1, 3, 0, 'h22, 'h11);

    // Jump inside the window is ignored.
    jmp(1'b0, 'h40, 'h01);
    jmp(1'b0, 'h80, 'h3F);
    alu(1, 1, 0, 1, 1);
    alu(1, 1, 0, 1, 1);
    alu(2, 4, 0, 9, 2);

    // Sequential JMP behaves as a NOP.
    jmp(1'b1, 'hFF, 'h3F);
    alu(1, 5, 0, 7, 7);

    // Reset in the middle of a window.
    jmp(1'b0, 'h00, 'h2A);
    do_reset();
    alu(1, 6, 0, 'h80, 'h80);

    // Randomized traffic with narrow register indices to provoke forwarding.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(39) == 0) do_reset();
      else issue(1'b0, int'($urandom_range(3)), int'($urandom_range(3)),
                 int'($urandom_range(3)), int'($urandom_range(255)),
                 ($urandom_range(3) == 0) ? 0 : int'($urandom_range(255)),
                 int'($urandom_range(63)), int'($urandom_range(255)),
                 1'($urandom_range(1)), ($urandom_range(4) != 0),
                 ($urandom_range(5) != 0));
    end

    // Drain (bounded), then confirm every expectation was consumed.
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute stage plus EX/WB pipeline register of the 8-bit core; consumes the registered outputs of the ID/EX register directly.
- Performs the ALU operation, forwards the previous result into operand A, resolves jumps, and squashes younger wrong-path instructions after a taken jump.
- Registered outputs feed the register-file write port (writeback) and the PC-select logic in fetch.

Parameters:
SQUASH_DEPTH, 2, number of instructions discarded after a taken jump (range 1-3; 2-bit counter)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset, sampled on posedge clk
num1  input  8  register operand from ID/EX (rs value)
ImmData_out  input  8  immediate operand from ID/EX
inst_code_idex_out  input  8  instruction: [7:6] opcode, [5:3] rd, [2:0] rs
j_adr_out  input  6  jump address field
PCline_idex_out  input  8  PC of this instruction
PCsrc_idex_out  input  1  0 = jump candidate, 1 = sequential
Sel1_idex_out  input  1  operand-A select: 1 = register/forwarded value, 0 = zero
RegWrite_idex_out  input  1  write-enable from decode
WriteData_exwb_out  output  8  result to register file
WriteReg_exwb_out  output  3  destination register
RegWrite_exwb_out  output  1  register write enable
jump_taken  output  1  one-cycle pulse, PC must load jump_target
jump_target  output  8  {PCline_idex_out[7:6], j_adr_out}
flush  output  1  one-cycle pulse, IF/ID and ID/EX contents are wrong-path
carry_flag  output  1  carry/borrow of last ADD/SUB
zero_flag  output  1  result==0 of last ADD/SUB

Behaviour:
- Reset (reset=1 at posedge): all outputs 0, squash counter 0, forwarding state cleared. Reset has priority over every other event, including an in-progress squash window.
- Latency: one cycle; every output is registered and reflects the inputs sampled at the preceding posedge.
- Squashed = squash counter != 0 at the sampling edge. A squashed instruction is a bubble: RegWrite_exwb_out<=0, jump_taken<=0, flags hold, WriteData/WriteReg hold, counter decrements by 1.
- Forwarding: fwd = RegWrite_exwb_out & (WriteReg_exwb_out == inst[2:0]). A_raw = fwd ? WriteData_exwb_out : num1. A = Sel1 ? A_raw : 8'h00.
- Opcode 00 MOVI: result = ImmData_out; flags hold.
- Opcode 01 ADD: {c,result} = A + ImmData_out (9-bit); carry_flag<=c; zero_flag<=(result==0); modulo 256 wrap.
- Opcode 10 SUB: result = A - ImmData_out mod 256; carry_flag<=(A < ImmData_out) (borrow); zero_flag<=(result==0).
- Opcodes 00/01/10 (not squashed): WriteData<=result, WriteReg<=inst[5:3], RegWrite_exwb_out<=RegWrite_idex_out.
- Opcode 11 JMP (not squashed): RegWrite_exwb_out<=0; WriteData/WriteReg/flags hold. If PCsrc_idex_out==0: jump_taken<=1, flush<=1, jump_target<={PCline[7:6],j_adr}, counter<=SQUASH_DEPTH. If PCsrc_idex_out==1: no jump, behaves as a NOP.
- jump_taken and flush return to 0 on the next edge. jump_target holds its value until the next taken jump.
- A jump arriving while squashed is ignored; the counter is never reloaded mid-window.
- Forwarding source is always the last non-bubble write. A bubble clears RegWrite_exwb_out, so no forwarding occurs from it.

Test Plan:
- Reset: reset=1 for 2 cycles with arbitrary inputs -> all outputs 0; after release, MOVI rd=3 imm=8'h5A -> next cycle WriteData=5A, WriteReg=3, RegWrite=1, flags 0.
- ADD wrap: Sel1=1, num1=8'hF0, imm=8'h20, opcode 01 -> WriteData=8'h10, carry=1, zero=0. Then SUB with A=8'h05, imm=8'h05 -> 00, carry=0, zero=1. Then SUB with A=8'h03, imm=8'h04 -> FF, carry=1.
- Forwarding: MOVI r2<=8'h07, next ADD rd=1 rs=2 num1=8'h00 (stale) imm=1 -> WriteData=08. Same sequence with RegWrite_idex_out=0 on the MOVI -> 01.
- Jump/squash (SQUASH_DEPTH=2): JMP PCsrc=0 PCline=8'hC4 j_adr=6'h15 -> jump_taken=1, flush=1 for exactly one cycle, target=8'hD5. The next 2 ADDs produce RegWrite=0 with flags unchanged; the 3rd ADD writes normally.
- Jump inside squash window: JMP taken, then second JMP (PCsrc=0) as the next instruction -> no second jump_taken pulse, window ends after 2 bubbles. JMP with PCsrc=1 -> no pulse, no squash.
- Reset mid-window: assert reset the cycle after a taken jump -> outputs 0, counter 0; the first instruction after release executes (not squashed).
